// File: rtl/collision_checker.sv
// collision_checker: frame-synchronous collision detector for the T-rex and
// the front obstacle. A check pulse snapshots the geometry, a coarse outer-box
// test runs, and (optionally) a sequential box-pair scan follows. The result
// is reported with a one-cycle done strobe and a sticky crash flag.
//
// Build option: define COLLISION_FINE_CHECK_EN to build the per-box INNER scan.
// Without it, an outer-box overlap is itself a hit and the result is always
// ready one edge after the snapshot edge.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for check; snapshot taken on check
// OUTER | coarse test on the 1 px inset outer boxes
// INNER | one T-rex/obstacle box pair tested per cycle
// DONE  | done strobe high for one cycle, then back to IDLE

package collision_pkg;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] width;
        logic [9:0] height;
    } collision_box_t;
endpackage

package obstacle_pkg;
    localparam int COLLISION_BOX_COUNT = 7;
endpackage

module collision_checker #(
    parameter int TREX_BOX_COUNT     = 7,
    parameter int OBSTACLE_BOX_COUNT = obstacle_pkg::COLLISION_BOX_COUNT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          check,
    input  logic                          clear,
    input  logic signed [10:0]            trex_x_pos,
    input  logic        [9:0]             trex_y_pos,
    input  logic        [9:0]             trex_width,
    input  logic        [9:0]             trex_height,
    input  collision_pkg::collision_box_t trex_box [TREX_BOX_COUNT],
    input  logic                          obstacle_valid,
    input  logic signed [10:0]            obstacle_x_pos,
    input  logic        [9:0]             obstacle_y_pos,
    input  logic        [9:0]             obstacle_width,
    input  logic        [9:0]             obstacle_height,
    input  collision_pkg::collision_box_t obstacle_box [OBSTACLE_BOX_COUNT],
    output logic                          busy,
    output logic                          done,
    output logic                          crash
);

    // Zero-extend an unsigned 10-bit quantity into the 12-bit signed domain.
    function automatic logic signed [11:0] ext10(input logic [9:0] v);
        return {2'b00, v};
    endfunction

    // Half-open rectangle overlap; a box with non-positive size never overlaps,
    // which lets unused box slots be all-zero and covers outer boxes under 2 px.
    function automatic logic boxes_overlap(
        input logic signed [11:0] ax, input logic signed [11:0] ay,
        input logic signed [11:0] aw, input logic signed [11:0] ah,
        input logic signed [11:0] bx, input logic signed [11:0] by,
        input logic signed [11:0] bw, input logic signed [11:0] bh
    );
        if (aw <= 12'sd0 || ah <= 12'sd0 || bw <= 12'sd0 || bh <= 12'sd0)
            return 1'b0;
        return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
    endfunction

`ifdef COLLISION_FINE_CHECK_EN
    typedef enum logic [1:0] {IDLE, OUTER, INNER, DONE} state_t;
    localparam int TW = (TREX_BOX_COUNT > 1) ? $clog2(TREX_BOX_COUNT) : 1;
    localparam int OW = (OBSTACLE_BOX_COUNT > 1) ? $clog2(OBSTACLE_BOX_COUNT) : 1;
    localparam logic [TW-1:0] I_LAST = TW'(TREX_BOX_COUNT - 1);
    localparam logic [OW-1:0] J_LAST = OW'(OBSTACLE_BOX_COUNT - 1);

    logic [TW-1:0]                 i_idx;
    logic [OW-1:0]                 j_idx;
    collision_pkg::collision_box_t snap_trex_box [TREX_BOX_COUNT];
    collision_pkg::collision_box_t snap_obs_box  [OBSTACLE_BOX_COUNT];
    collision_pkg::collision_box_t tbox;
    collision_pkg::collision_box_t obox;
    logic                          pair_hit;
`else
    typedef enum logic [1:0] {IDLE, OUTER, DONE} state_t;
`endif

    state_t             state;
    logic               snap_valid;
    logic signed [11:0] snap_tx, snap_ty, snap_tw, snap_th;
    logic signed [11:0] snap_ox, snap_oy, snap_ow, snap_oh;
    logic               outer_hit;

    // Coarse test on the outer boxes, each inset by 1 px on every side.
    always_comb begin
        outer_hit = snap_valid &&
                    boxes_overlap(snap_tx + 12'sd1, snap_ty + 12'sd1,
                                  snap_tw - 12'sd2, snap_th - 12'sd2,
                                  snap_ox + 12'sd1, snap_oy + 12'sd1,
                                  snap_ow - 12'sd2, snap_oh - 12'sd2);
    end

`ifdef COLLISION_FINE_CHECK_EN
    // Current box pair, each box translated by its owner's origin.
    always_comb begin
        tbox     = snap_trex_box[i_idx];
        obox     = snap_obs_box[j_idx];
        pair_hit = boxes_overlap(snap_tx + ext10(tbox.x), snap_ty + ext10(tbox.y),
                                 ext10(tbox.width), ext10(tbox.height),
                                 snap_ox + ext10(obox.x), snap_oy + ext10(obox.y),
                                 ext10(obox.width), ext10(obox.height));
    end
`endif

    // Sequencer: snapshot, outer test, optional pair scan, result strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            crash      <= 1'b0;
            snap_valid <= 1'b0;
            snap_tx    <= '0;
            snap_ty    <= '0;
            snap_tw    <= '0;
            snap_th    <= '0;
            snap_ox    <= '0;
            snap_oy    <= '0;
            snap_ow    <= '0;
            snap_oh    <= '0;
`ifdef COLLISION_FINE_CHECK_EN
            i_idx      <= '0;
            j_idx      <= '0;
            for (int t = 0; t < TREX_BOX_COUNT; t++) snap_trex_box[t] <= '0;
            for (int o = 0; o < OBSTACLE_BOX_COUNT; o++) snap_obs_box[o] <= '0;
`endif
        end else if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            crash <= 1'b0;
`ifdef COLLISION_FINE_CHECK_EN
            i_idx <= '0;
            j_idx <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (check) begin
                        snap_valid <= obstacle_valid;
                        snap_tx    <= {trex_x_pos[10], trex_x_pos};
                        snap_ty    <= ext10(trex_y_pos);
                        snap_tw    <= ext10(trex_width);
                        snap_th    <= ext10(trex_height);
                        snap_ox    <= {obstacle_x_pos[10], obstacle_x_pos};
                        snap_oy    <= ext10(obstacle_y_pos);
                        snap_ow    <= ext10(obstacle_width);
                        snap_oh    <= ext10(obstacle_height);
`ifdef COLLISION_FINE_CHECK_EN
                        snap_trex_box <= trex_box;
                        snap_obs_box  <= obstacle_box;
                        i_idx         <= '0;
                        j_idx         <= '0;
`endif
                        busy  <= 1'b1;
                        state <= OUTER;
                    end
                end
                OUTER: begin
`ifdef COLLISION_FINE_CHECK_EN
                    if (outer_hit) begin
                        state <= INNER;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
`else
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    crash <= crash | outer_hit;
                    state <= DONE;
`endif
                end
`ifdef COLLISION_FINE_CHECK_EN
                INNER: begin
                    if (pair_hit || (i_idx == I_LAST && j_idx == J_LAST)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        crash <= crash | pair_hit;
                        state <= DONE;
                    end else if (j_idx == J_LAST) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_checker.sv
// Testbench for collision_checker: scenario tasks with a queue of expected
// results pushed at each check and popped when done appears.
module tb_collision_checker;
    import collision_pkg::*;

`ifdef COLLISION_FINE_CHECK_EN
    localparam bit FINE = 1'b1;
`else
    localparam bit FINE = 1'b0;
`endif
    localparam int NT = 7;
    localparam int NO = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic check = 1'b0;
    logic clear = 1'b0;
    logic signed [10:0] trex_x_pos = '0;
    logic [9:0] trex_y_pos = '0, trex_width = '0, trex_height = '0;
    collision_box_t trex_box [NT];
    logic obstacle_valid = 1'b0;
    logic signed [10:0] obstacle_x_pos = '0;
    logic [9:0] obstacle_y_pos = '0, obstacle_width = '0, obstacle_height = '0;
    collision_box_t obstacle_box [NO];
    logic busy, done, crash;

    typedef struct {
        int   lat;
        logic crash;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    collision_checker #(.TREX_BOX_COUNT(NT), .OBSTACLE_BOX_COUNT(NO)) dut (
        .clk(clk), .rst(rst), .check(check), .clear(clear),
        .trex_x_pos(trex_x_pos), .trex_y_pos(trex_y_pos),
        .trex_width(trex_width), .trex_height(trex_height), .trex_box(trex_box),
        .obstacle_valid(obstacle_valid), .obstacle_x_pos(obstacle_x_pos),
        .obstacle_y_pos(obstacle_y_pos), .obstacle_width(obstacle_width),
        .obstacle_height(obstacle_height), .obstacle_box(obstacle_box),
        .busy(busy), .done(done), .crash(crash)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_count++;

    task automatic set_scene(input int tx, input int ty, input int tw, input int th,
                             input int ox, input int oy, input int ow, input int oh,
                             input logic v);
        trex_x_pos      = 11'(tx);
        trex_y_pos      = 10'(ty);
        trex_width      = 10'(tw);
        trex_height     = 10'(th);
        obstacle_x_pos  = 11'(ox);
        obstacle_y_pos  = 10'(oy);
        obstacle_width  = 10'(ow);
        obstacle_height = 10'(oh);
        obstacle_valid  = v;
    endtask

    // One full-size box per owner, all other slots zero-size.
    task automatic boxes_single();
        for (int t = 0; t < NT; t++) trex_box[t] = '0;
        for (int o = 0; o < NO; o++) obstacle_box[o] = '0;
        trex_box[0]     = '{10'd0, 10'd0, 10'd44, 10'd47};
        obstacle_box[0] = '{10'd0, 10'd0, 10'd17, 10'd35};
    endtask

    // Small boxes that miss each other inside overlapping outer boxes;
    // with_hit adds a T-rex box 1 that meets obstacle box 0 (pair k=7).
    task automatic boxes_scan(input bit with_hit);
        for (int t = 0; t < NT; t++) trex_box[t] = '{10'd0, 10'd0, 10'd10, 10'd10};
        for (int o = 0; o < NO; o++) obstacle_box[o] = '0;
        obstacle_box[0] = '{10'd10, 10'd20, 10'd5, 10'd5};
        if (with_hit) trex_box[1] = '{10'd30, 10'd0, 10'd14, 10'd47};
    endtask

    task automatic run_check(input string name, input int lat, input logic exp_crash);
        exp_t e;
        int   got;
        exp_q.push_back('{lat, exp_crash});
        @(negedge clk) check = 1'b1;
        @(posedge clk);
        #1 check = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_e0: got %b want 1", name, busy);
        end
        got = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                got = n;
                break;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (got != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d (0 = no done)", name, got, e.lat);
        end
        checks++;
        if (crash !== e.crash) begin
            errors++;
            $display("FAIL %s crash: got %b want %b", name, crash, e.crash);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        @(posedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        checks++;
        if (crash !== 1'b0) begin
            errors++;
            $display("FAIL clear crash: got %b want 0", crash);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        if (crash !== 1'b0) begin errors++; $display("FAIL reset crash: got %b want 0", crash); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_outer_miss();
        boxes_single();
        set_scene(50, 93, 44, 47, 200, 105, 17, 35, 1'b1);
        run_check("outer_miss", 1, 1'b0);
    endtask

    task automatic test_fine_hit_sticky();
        boxes_single();
        set_scene(50, 93, 44, 47, 80, 105, 17, 35, 1'b1);
        run_check("fine_hit", FINE ? 2 : 1, 1'b1);
        set_scene(50, 93, 44, 47, 200, 105, 17, 35, 1'b1);
        for (int r = 0; r < 10; r++) run_check("sticky", 1, 1'b1);
        do_clear();
    endtask

    task automatic test_inner_miss();
        boxes_scan(1'b0);
        set_scene(50, 93, 44, 47, 80, 105, 17, 35, 1'b1);
        run_check("inner_miss", FINE ? 1 + NT * NO : 1, FINE ? 1'b0 : 1'b1);
        do_clear();
    endtask

    task automatic test_hit_at_k();
        boxes_scan(1'b1);
        set_scene(50, 93, 44, 47, 80, 105, 17, 35, 1'b1);
        run_check("hit_k7", FINE ? 2 + 7 : 1, 1'b1);
        do_clear();
    endtask

    task automatic test_edges();
        boxes_single();
        set_scene(50, 93, 44, 47, 92, 105, 17, 35, 1'b1);
        run_check("edge_touch", 1, 1'b0);
        set_scene(50, 93, 44, 47, 91, 105, 17, 35, 1'b1);
        run_check("edge_overlap", FINE ? 2 : 1, 1'b1);
        do_clear();
        set_scene(2, 93, 44, 47, -30, 105, 17, 35, 1'b1);
        run_check("neg_x_miss", 1, 1'b0);
        set_scene(2, 93, 44, 47, -5, 105, 17, 35, 1'b1);
        run_check("neg_x_hit", FINE ? 2 : 1, 1'b1);
        do_clear();
    endtask

    task automatic test_invalid();
        boxes_single();
        set_scene(50, 93, 44, 47, 50, 93, 44, 47, 1'b0);
        run_check("invalid", 1, 1'b0);
    endtask

    task automatic test_clear_mid();
        int dc0;
        int d;
        boxes_single();
        set_scene(50, 93, 44, 47, 80, 105, 17, 35, 1'b1);
        run_check("pre_clear_hit", FINE ? 2 : 1, 1'b1);
        boxes_scan(1'b0);
        d   = FINE ? 3 : 1;
        dc0 = done_count;
        @(negedge clk) check = 1'b1;
        @(posedge clk);
        #1 check = 1'b0;
        repeat (d - 1) @(posedge clk);
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear_mid busy: got %b want 0", busy); end
        if (crash !== 1'b0) begin errors++; $display("FAIL clear_mid crash: got %b want 0", crash); end
        if (done !== 1'b0) begin errors++; $display("FAIL clear_mid done: got %b want 0", done); end
        if (done_count != dc0) begin
            errors++;
            $display("FAIL clear_mid done_seen: got %0d want %0d", done_count - dc0, 0);
        end
        run_check("after_clear", FINE ? 1 + NT * NO : 1, FINE ? 1'b0 : 1'b1);
        do_clear();
    endtask

    task automatic test_ignored_check();
        int dc0;
        boxes_scan(1'b0);
        set_scene(50, 93, 44, 47, 80, 105, 17, 35, 1'b1);
        dc0 = done_count;
        @(negedge clk) check = 1'b1;
        repeat (3) @(posedge clk);
        #1 check = 1'b0;
        repeat (60) @(negedge clk);
        checks += 2;
        if (done_count - dc0 != 1) begin
            errors++;
            $display("FAIL ignored_check done_count: got %0d want 1", done_count - dc0);
        end
        if (crash !== (FINE ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL ignored_check crash: got %b want %b", crash, FINE ? 1'b0 : 1'b1);
        end
        do_clear();
    endtask

    task automatic test_async_reset();
        boxes_single();
        set_scene(50, 93, 44, 47, 80, 105, 17, 35, 1'b1);
        run_check("pre_rst_hit", FINE ? 2 : 1, 1'b1);
        boxes_scan(1'b0);
        @(negedge clk) check = 1'b1;
        @(posedge clk);
        #1 check = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL async_rst busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL async_rst busy: got %b want 0", busy); end
        if (crash !== 1'b0) begin errors++; $display("FAIL async_rst crash: got %b want 0", crash); end
        if (done !== 1'b0) begin errors++; $display("FAIL async_rst done: got %b want 0", done); end
        @(negedge clk) rst = 1'b0;
        boxes_single();
        set_scene(50, 93, 44, 47, 200, 105, 17, 35, 1'b1);
        run_check("post_rst", 1, 1'b0);
    endtask

    initial begin
        for (int t = 0; t < NT; t++) trex_box[t] = '0;
        for (int o = 0; o < NO; o++) obstacle_box[o] = '0;
        test_reset();
        test_outer_miss();
        test_fine_hit_sticky();
        test_inner_miss();
        test_hit_at_k();
        test_edges();
        test_invalid();
        test_clear_mid();
        test_ignored_check();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
